dma_line_sched: RTL and testbench
=================================

DMA_LINE_SCHED -- requirements
Module: dma_line_sched

Interface
REQ-001 SHALL have parameter STARTUP_CYC, default 16: mclk0 ticks of DMA startup overhead between halt assertion and fetch_start.
REQ-002 SHALL have parameter SHUTDOWN_CYC, default 8: mclk0 ticks of DMA shutdown overhead between fetch_done and halt release.
REQ-003 SHALL have port clk  input  1  system clock; sole clock.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mclk0  input  1  7.16 MHz clock enable; all state and counter updates occur only on clk edges with mclk0=1.
REQ-006 SHALL have port dma_en  input  1  DMA enable from control register.
REQ-007 SHALL have ports vbe, hbs, lrc  input  1 each  single-cycle pulses from video sync: vblank end (row 16, col 0), hblank start (col 440), line reset count (col 412).
REQ-008 SHALL have port vblank  input  1  vertical blank level.
REQ-009 SHALL have ports fetch_done and fetch_dli  input  1 each: fetcher completion pulse, and the DLI flag of the zone just fetched, valid with fetch_done.
REQ-010 SHALL have outputs halt (level), dll_load, fetch_start, fetch_abort, line_swap and nmi (pulses), each 1 bit wide.
REQ-011 SHALL have output overrun_cnt  8  saturating count of aborted fetches this frame.
REQ-012 SHALL have output busy  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement the states IDLE, WAIT_LINE, STARTUP, FETCH, SHUTDOWN.
REQ-014 SHALL make every pulse output exactly one mclk0 period wide: asserted from one mclk0 edge to the next.
REQ-015 IDLE: on vbe with dma_en=1, SHALL pulse dll_load, clear overrun_cnt and go to WAIT_LINE; with dma_en=0, SHALL stay in IDLE.
REQ-016 WAIT_LINE: on hbs with vblank=0 and dma_en=1, SHALL assert halt, load the counter with STARTUP_CYC-1 and go to STARTUP.
REQ-017 WAIT_LINE: on hbs with dma_en=0, SHALL go to IDLE with halt=0.
REQ-018 STARTUP: SHALL decrement the counter each mclk0 tick; at 0, SHALL pulse fetch_start and go to FETCH; fetch_start SHALL rise exactly STARTUP_CYC ticks after halt rises.
REQ-019 FETCH: on fetch_done, SHALL latch fetch_dli into dli_pend, load the counter with SHUTDOWN_CYC-1 and go to SHUTDOWN.
REQ-020 SHUTDOWN: SHALL count down; at 0, SHALL deassert halt and go to WAIT_LINE; if dli_pend=1, SHALL pulse nmi on the same tick and clear dli_pend.
REQ-021 SHALL pulse line_swap on every lrc while busy=1, regardless of state.
REQ-022 On lrc while in FETCH (overrun), SHALL pulse fetch_abort, increment overrun_cnt saturating at 255, discard the DLI, deassert halt and go to WAIT_LINE; SHALL pulse line_swap on the same tick.
REQ-023 On lrc while in STARTUP, SHALL go to WAIT_LINE with halt=0, with no fetch_start and no abort.
REQ-024 On a vblank rising edge (detected internally) in any non-IDLE state, SHALL go to IDLE with halt=0 and clear dli_pend; if in FETCH, SHALL pulse fetch_abort without incrementing overrun_cnt.
REQ-025 Precedence on the same tick SHALL be: vblank rise > lrc > fetch_done > counter expiry; fetch_done coincident with lrc in FETCH SHALL count as completion (no abort) and enter SHUTDOWN.
REQ-026 SHALL ignore fetch_done outside FETCH.
REQ-027 SHALL ignore vbe outside IDLE.
REQ-028 SHALL ignore hbs outside WAIT_LINE.
REQ-029 The counter SHALL be 8 bits wide; STARTUP_CYC and SHUTDOWN_CYC SHALL be in the range 1..255.

Reset
REQ-030 While reset_n=0, SHALL hold state IDLE, counter 0, dli_pend 0, overrun_cnt 0, vblank edge register 0, and all outputs 0.
REQ-031 Assertion of reset_n SHALL take effect immediately (asynchronously) and abort any operation in progress without an abort pulse; after release, the block SHALL wait for the next vbe.

Verification
REQ-032 dma_en=1, vbe pulse, then hbs with vblank=0 -> dll_load 1 tick; halt rises; fetch_start exactly 16 mclk0 ticks after halt; fetch_done 100 ticks later -> halt falls 8 ticks after fetch_done; busy=1 throughout.
REQ-033 fetch_done with fetch_dli=1 -> nmi pulses on the same tick halt falls; next line with fetch_dli=0 -> no nmi.
REQ-034 FETCH held through lrc -> fetch_abort and line_swap on the same tick, halt=0, overrun_cnt=1; 300 consecutive overruns -> overrun_cnt=255; next vbe -> overrun_cnt=0.
REQ-035 fetch_done and lrc on the same tick -> no fetch_abort, overrun_cnt unchanged, SHUTDOWN entered, halt falls 8 ticks later.
REQ-036 vblank rises mid-FETCH -> fetch_abort, halt=0, IDLE, overrun_cnt unchanged; dma_en cleared mid-frame -> next hbs gives IDLE with no halt.
REQ-037 reset_n pulled low mid-STARTUP between clk edges -> halt=0 immediately; after release, hbs is ignored until vbe.

Source files
------------

// File: rtl/dma_line_sched.sv
// Per-line DMA scheduler: brackets each display-list fetch with CPU halt, startup/shutdown
// overhead and DLI/NMI delivery, and aborts fetches that overrun the line reset point.
module dma_line_sched #(
    parameter int unsigned STARTUP_CYC  = 16,
    parameter int unsigned SHUTDOWN_CYC = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       mclk0,
    input  logic       dma_en,
    input  logic       vbe,
    input  logic       hbs,
    input  logic       lrc,
    input  logic       vblank,
    input  logic       fetch_done,
    input  logic       fetch_dli,
    output logic       halt,
    output logic       dll_load,
    output logic       fetch_start,
    output logic       fetch_abort,
    output logic       line_swap,
    output logic       nmi,
    output logic [7:0] overrun_cnt,
    output logic       busy
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned OVR_W = 8;
    localparam logic [CNT_W-1:0] START_LD = CNT_W'(STARTUP_CYC - 1);
    localparam logic [CNT_W-1:0] SHUT_LD  = CNT_W'(SHUTDOWN_CYC - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT     = 3'd1;
    localparam logic [2:0] S_STARTUP  = 3'd2;
    localparam logic [2:0] S_FETCH    = 3'd3;
    localparam logic [2:0] S_SHUTDOWN = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OVR_W-1:0] ovr_q, ovr_d;
    logic             dli_pend_q, dli_pend_d;
    logic             vblank_q, vblank_d;
    logic             halt_q, halt_d;
    logic             dll_load_q, dll_load_d;
    logic             fetch_start_q, fetch_start_d;
    logic             fetch_abort_q, fetch_abort_d;
    logic             line_swap_q, line_swap_d;
    logic             nmi_q, nmi_d;
    logic             busy_q, busy_d;
    logic             vb_rise_c;

    // All state advances only on mclk0 ticks, so every pulse lasts one mclk0 period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            ovr_q         <= '0;
            dli_pend_q    <= 1'b0;
            vblank_q      <= 1'b0;
            halt_q        <= 1'b0;
            dll_load_q    <= 1'b0;
            fetch_start_q <= 1'b0;
            fetch_abort_q <= 1'b0;
            line_swap_q   <= 1'b0;
            nmi_q         <= 1'b0;
            busy_q        <= 1'b0;
        end else if (mclk0) begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ovr_q         <= ovr_d;
            dli_pend_q    <= dli_pend_d;
            vblank_q      <= vblank_d;
            halt_q        <= halt_d;
            dll_load_q    <= dll_load_d;
            fetch_start_q <= fetch_start_d;
            fetch_abort_q <= fetch_abort_d;
            line_swap_q   <= line_swap_d;
            nmi_q         <= nmi_d;
            busy_q        <= busy_d;
        end
    end

    assign vb_rise_c = vblank & ~vblank_q;

    // Next state; vblank rise beats lrc beats fetch_done beats counter expiry.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ovr_d         = ovr_q;
        dli_pend_d    = dli_pend_q;
        vblank_d      = vblank;
        halt_d        = halt_q;
        dll_load_d    = 1'b0;
        fetch_start_d = 1'b0;
        fetch_abort_d = 1'b0;
        nmi_d         = 1'b0;
        line_swap_d   = lrc & (state_q != S_IDLE);

        if ((state_q != S_IDLE) && vb_rise_c) begin
            state_d       = S_IDLE;
            halt_d        = 1'b0;
            dli_pend_d    = 1'b0;
            fetch_abort_d = (state_q == S_FETCH);
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (vbe && dma_en) begin
                        dll_load_d = 1'b1;
                        ovr_d      = '0;
                        state_d    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (hbs) begin
                        if (!dma_en) begin
                            state_d = S_IDLE;
                            halt_d  = 1'b0;
                        end else if (!vblank) begin
                            halt_d  = 1'b1;
                            cnt_d   = START_LD;
                            state_d = S_STARTUP;
                        end
                    end
                end
                S_STARTUP: begin
                    if (lrc) begin
                        state_d = S_WAIT;
                        halt_d  = 1'b0;
                    end else if (cnt_q == '0) begin
                        fetch_start_d = 1'b1;
                        state_d       = S_FETCH;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_FETCH: begin
                    // A fetch that completes on the lrc tick still counts as on time.
                    if (fetch_done) begin
                        dli_pend_d = fetch_dli;
                        cnt_d      = SHUT_LD;
                        state_d    = S_SHUTDOWN;
                    end else if (lrc) begin
                        fetch_abort_d = 1'b1;
                        ovr_d         = (ovr_q == '1) ? ovr_q : ovr_q + OVR_W'(1);
                        dli_pend_d    = 1'b0;
                        halt_d        = 1'b0;
                        state_d       = S_WAIT;
                    end
                end
                S_SHUTDOWN: begin
                    if (cnt_q == '0) begin
                        halt_d     = 1'b0;
                        nmi_d      = dli_pend_q;
                        dli_pend_d = 1'b0;
                        state_d    = S_WAIT;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    halt_d  = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    assign halt        = halt_q;
    assign dll_load    = dll_load_q;
    assign fetch_start = fetch_start_q;
    assign fetch_abort = fetch_abort_q;
    assign line_swap   = line_swap_q;
    assign nmi         = nmi_q;
    assign overrun_cnt = ovr_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_dma_line_sched.sv
// Directed bench for dma_line_sched: a timestamp-based line model is compared every clock,
// plus literal checks of the key latencies and counts.
module tb_dma_line_sched;

    localparam int unsigned STARTUP_CYC  = 16;
    localparam int unsigned SHUTDOWN_CYC = 8;

    localparam int P_IDLE = 0, P_WAIT = 1, P_START = 2, P_FETCH = 3, P_SHUT = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       mclk0;
    logic       dma_en = 1'b0;
    logic       vbe = 1'b0, hbs = 1'b0, lrc = 1'b0, vblank = 1'b0;
    logic       fetch_done = 1'b0, fetch_dli = 1'b0;
    logic       halt, dll_load, fetch_start, fetch_abort, line_swap, nmi, busy;
    logic [7:0] overrun_cnt;

    int n_total = 0;
    int n_bad   = 0;
    int tk      = 0;
    bit chk_en  = 1'b0;

    dma_line_sched #(.STARTUP_CYC(STARTUP_CYC), .SHUTDOWN_CYC(SHUTDOWN_CYC)) dut (
        .clk(clk), .reset_n(reset_n), .mclk0(mclk0), .dma_en(dma_en),
        .vbe(vbe), .hbs(hbs), .lrc(lrc), .vblank(vblank),
        .fetch_done(fetch_done), .fetch_dli(fetch_dli),
        .halt(halt), .dll_load(dll_load), .fetch_start(fetch_start),
        .fetch_abort(fetch_abort), .line_swap(line_swap), .nmi(nmi),
        .overrun_cnt(overrun_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    // mclk0 is high on every other clk cycle.
    initial begin
        mclk0 = 1'b0;
        forever @(negedge clk) mclk0 = ~mclk0;
    end

    // Line model: phases plus absolute tick timestamps for the overhead windows.
    int   m_phase = P_IDLE;
    int   m_t = 0, m_halt_t = 0, m_done_t = 0, m_ovr = 0;
    bit   m_dli = 0, m_vbp = 0, vrise;
    logic e_dll = 0, e_fs = 0, e_ab = 0, e_ls = 0, e_nmi = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = P_IDLE; m_ovr = 0; m_dli = 0; m_vbp = 0; m_t = 0;
            e_dll = 0; e_fs = 0; e_ab = 0; e_ls = 0; e_nmi = 0;
        end else if (mclk0) begin
            m_t++;
            vrise = vblank && !m_vbp;
            m_vbp = vblank;
            e_dll = 0; e_fs = 0; e_ab = 0; e_nmi = 0;
            e_ls  = lrc && (m_phase != P_IDLE);
            if (vrise && m_phase != P_IDLE) begin
                e_ab = (m_phase == P_FETCH);
                m_phase = P_IDLE;
                m_dli = 0;
            end else if (m_phase == P_IDLE) begin
                if (vbe && dma_en) begin e_dll = 1; m_ovr = 0; m_phase = P_WAIT; end
            end else if (m_phase == P_WAIT) begin
                if (hbs && !dma_en) m_phase = P_IDLE;
                else if (hbs && !vblank) begin m_phase = P_START; m_halt_t = m_t; end
            end else if (m_phase == P_START) begin
                if (lrc) m_phase = P_WAIT;
                else if (m_t == m_halt_t + STARTUP_CYC) begin e_fs = 1; m_phase = P_FETCH; end
            end else if (m_phase == P_FETCH) begin
                if (fetch_done) begin m_dli = fetch_dli; m_done_t = m_t; m_phase = P_SHUT; end
                else if (lrc) begin
                    e_ab = 1; m_dli = 0; m_phase = P_WAIT;
                    if (m_ovr < 255) m_ovr++;
                end
            end else if (m_t == m_done_t + SHUTDOWN_CYC) begin
                e_nmi = m_dli; m_dli = 0; m_phase = P_WAIT;
            end
        end
    end

    // Every-clock comparison of the full output set against the model.
    always @(negedge clk) begin
        logic [14:0] act, exp;
        if (chk_en) begin
            exp = {(m_phase >= P_START), (m_phase != P_IDLE), e_dll, e_fs, e_ab, e_ls, e_nmi, 8'(m_ovr)};
            act = {halt, busy, dll_load, fetch_start, fetch_abort, line_swap, nmi, overrun_cnt};
            n_total++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL model_cmp t=%0t {halt,busy,dll,fs,ab,ls,nmi,ovr} got=%b_%h want=%b_%h",
                         $time, act[14:8], act[7:0], exp[14:8], exp[7:0]);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        do @(posedge clk); while (mclk0 !== 1'b1);
        #1;
        vbe = 0; hbs = 0; lrc = 0; fetch_done = 0; fetch_dli = 0;
        tk++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic until_fs(output int n);
        n = 0;
        do begin tick(); n++; end while (!fetch_start && n < 300);
        if (!fetch_start) chk("fetch_start_timeout", 0, 1);
    endtask

    task automatic until_halt_low(output int n, output int nmi_seen);
        n = 0; nmi_seen = 0;
        do begin tick(); n++; nmi_seen += int'(nmi); end while (halt && n < 300);
        if (halt) chk("halt_fall_timeout", 1, 0);
    endtask

    task automatic start_line();
        int n;
        hbs = 1; tick();
        until_fs(n);
    endtask

    initial begin
        int n, ns;
        chk_en = 1;
        repeat (6) @(posedge clk);
        #1;
        chk("reset_halt", int'(halt), 0);
        chk("reset_ovr", int'(overrun_cnt), 0);
        #10 reset_n = 1;

        // hbs before any vbe, and vbe with DMA disabled, are both ignored.
        hbs = 1; tick();
        vbe = 1; tick();
        chk("idle_no_busy", int'(busy), 0);

        dma_en = 1;
        vbe = 1; tick();
        chk("dll_load", int'(dll_load), 1);
        fetch_done = 1; tick();
        vbe = 1; tick();
        chk("vbe_ignored_busy", int'(dll_load), 0);

        // Normal line with DLI.
        hbs = 1; tick();
        chk("halt_rise", int'(halt), 1);
        until_fs(n);
        chk("startup_ticks", n, 16);
        ticks(99);
        fetch_done = 1; fetch_dli = 1; tick();
        until_halt_low(n, ns);
        chk("shutdown_ticks", n, 8);
        chk("nmi_on_halt_fall", int'(nmi), 1);

        // Next line without DLI.
        start_line();
        ticks(20);
        fetch_done = 1; tick();
        until_halt_low(n, ns);
        chk("no_nmi", ns, 0);

        // Overrun.
        start_line();
        ticks(4);
        lrc = 1; tick();
        chk("abort", int'(fetch_abort), 1);
        chk("abort_swap", int'(line_swap), 1);
        chk("abort_halt", int'(halt), 0);
        chk("ovr_one", int'(overrun_cnt), 1);

        // fetch_done coincident with lrc completes normally.
        start_line();
        fetch_done = 1; lrc = 1; tick();
        chk("coinc_no_abort", int'(fetch_abort), 0);
        chk("coinc_ovr", int'(overrun_cnt), 1);
        until_halt_low(n, ns);
        chk("coinc_shutdown", n, 8);

        // lrc during startup drops the line quietly.
        hbs = 1; tick();
        ticks(5);
        lrc = 1; tick();
        chk("start_lrc_halt", int'(halt), 0);
        ticks(20);

        for (int i = 0; i < 299; i++) begin
            start_line();
            lrc = 1; tick();
        end
        chk("ovr_sat", int'(overrun_cnt), 255);

        // vblank rise mid-fetch.
        start_line();
        ticks(3);
        vblank = 1; tick();
        chk("vb_abort", int'(fetch_abort), 1);
        chk("vb_idle", int'(busy), 0);
        chk("vb_ovr", int'(overrun_cnt), 255);
        ticks(3);
        vblank = 0; tick();
        vbe = 1; tick();
        chk("ovr_clear", int'(overrun_cnt), 0);

        // DMA disabled mid-frame.
        dma_en = 0;
        hbs = 1; tick();
        chk("dis_busy", int'(busy), 0);
        chk("dis_halt", int'(halt), 0);

        // Async reset during startup.
        dma_en = 1;
        vbe = 1; tick();
        hbs = 1; tick();
        ticks(5);
        @(posedge clk); #3;
        reset_n = 0;
        #1;
        chk("async_halt", int'(halt), 0);
        chk("async_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        #1 reset_n = 1;
        hbs = 1; tick();
        chk("post_rst_hbs", int'(halt), 0);
        vbe = 1; tick();
        chk("post_rst_dll", int'(dll_load), 1);
        hbs = 1; tick();
        chk("post_rst_halt", int'(halt), 1);
        ticks(3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
